if_fetch_unit: RTL and testbench

- Instruction-fetch front end; the producer side of the IF/ID pipeline register.
- Owns the PC and issues requests to the instruction memory over a req/ready handshake.
- Presents PC+4 and the fetched instruction to the IF/ID register.
- Raises fetch_stall while no instruction is available; the top level ORs this into the IF/ID freeze. Handles branch redirects, including redirects that arrive while a memory request is still outstanding.

---
 rtl/if_fetch_unit.sv | 114 +++++++++++
 tb/tb_if_fetch_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC and drives the instruction memory handshake.
// It feeds PC+step and the fetched word to the IF/ID register, and it handles redirects, including those that arrive during an outstanding request.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        fetch_stall
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] target_reg, target_nxt;
    logic [31:0] instr_buf, instr_buf_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            target_reg <= 32'h0;
            instr_buf  <= 32'h0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            target_reg <= target_nxt;
            instr_buf  <= instr_buf_nxt;
        end
    end

    assign imem_addr = pc;
    assign pc_out    = pc + STEP;

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        target_nxt      = target_reg;
        instr_buf_nxt   = instr_buf;
        imem_req        = 1'b0;
        fetch_stall     = 1'b1;
        instruction_out = instr_buf;

        case (state)
            IDLE: begin
                state_nxt = FETCH;
            end

            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    instruction_out = imem_rdata;
                    fetch_stall     = 1'b0;
                    if (branch_taken) begin
                        pc_nxt = branch_addr;
                    end else if (!freeze) begin
                        pc_nxt = pc + STEP;
                    end else begin
                        instr_buf_nxt = imem_rdata;
                        state_nxt     = HOLD;
                    end
                end else if (branch_taken) begin
                    // pc stays put so the in-flight address remains stable until ready
                    target_nxt = branch_addr;
                    state_nxt  = DISCARD;
                end
            end

            HOLD: begin
                fetch_stall = 1'b0;
                if (branch_taken) begin
                    pc_nxt    = branch_addr;
                    state_nxt = FETCH;
                end else if (!freeze) begin
                    pc_nxt    = pc + STEP;
                    state_nxt = FETCH;
                end
            end

            DISCARD: begin
                imem_req = 1'b1;
                if (branch_taken) begin
                    target_nxt = branch_addr;
                end
                if (imem_ready) begin
                    pc_nxt    = branch_taken ? branch_addr : target_reg;
                    state_nxt = FETCH;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios followed by random traffic, all checked against a flag-based fetch model.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        fetch_stall;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: PC, pending redirect, held word, and progress flags.
    logic [31:0] m_pc, m_tgt, m_buf;
    bit          m_started, m_held, m_disc;

    if_fetch_unit #(.RESET_PC(32'h0), .PC_STEP(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .fetch_stall     (fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc      = 32'h0;
        m_tgt     = 32'h0;
        m_buf     = 32'h0;
        m_started = 0;
        m_held    = 0;
        m_disc    = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic        e_req, e_stall;
        logic [31:0] e_instr;
        e_req   = m_started && !m_held;
        e_stall = !m_started || m_disc || (!m_held && !imem_ready);
        e_instr = (m_started && !m_held && !m_disc && imem_ready) ? imem_rdata : m_buf;
        chk({tag, ".req"},   32'(imem_req),    32'(e_req));
        chk({tag, ".addr"},  imem_addr,        m_pc);
        chk({tag, ".pcout"}, pc_out,           m_pc + 32'd4);
        chk({tag, ".stall"}, 32'(fetch_stall), 32'(e_stall));
        chk({tag, ".instr"}, instruction_out,  e_instr);
    endtask

    task automatic model_update();
        if (!m_started) begin
            m_started = 1;
        end else if (m_held) begin
            if (branch_taken) begin
                m_pc   = branch_addr;
                m_held = 0;
            end else if (!freeze) begin
                m_pc   = m_pc + 32'd4;
                m_held = 0;
            end
        end else if (m_disc) begin
            if (imem_ready) begin
                m_pc   = branch_taken ? branch_addr : m_tgt;
                m_disc = 0;
            end
            if (branch_taken) m_tgt = branch_addr;
        end else if (imem_ready) begin
            if (branch_taken)  m_pc = branch_addr;
            else if (!freeze)  m_pc = m_pc + 32'd4;
            else begin
                m_buf  = imem_rdata;
                m_held = 1;
            end
        end else if (branch_taken) begin
            m_tgt  = branch_addr;
            m_disc = 1;
        end
    endtask

    // One clock: drive at posedge+1, check at negedge, advance the model, return at posedge+1.
    task automatic step(input string tag, input logic rdy, input logic fr,
                        input logic br, input logic [31:0] ba);
        imem_ready   = rdy;
        freeze       = fr;
        branch_taken = br;
        branch_addr  = ba;
        imem_rdata   = m_pc ^ 32'hA5A5_0000;
        @(negedge clk);
        check_outputs(tag);
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        imem_ready   = 1'b0;
        imem_rdata   = 32'h0;
        model_reset();
        #2;
        chk("reset.req",   32'(imem_req),    32'h0);
        chk("reset.stall", 32'(fetch_stall), 32'h1);
        chk("reset.pcout", pc_out,           32'h4);
        chk("reset.instr", instruction_out,  32'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Zero-wait streaming
        step("idle", 1, 0, 0, 0);
        chk("first.addr", imem_addr, 32'h0);
        step("seq0", 1, 0, 0, 0);
        chk("seq.addr4", imem_addr, 32'h4);
        step("seq4", 1, 0, 0, 0);
        chk("seq.addr8", imem_addr, 32'h8);
        // Three wait cycles at pc=8
        step("wait8a", 0, 0, 0, 0);
        step("wait8b", 0, 0, 0, 0);
        step("wait8c", 0, 0, 0, 0);
        chk("wait.addr", imem_addr, 32'h8);
        step("ready8", 1, 0, 0, 0);
        step("seq12", 1, 0, 0, 0);
        // Freeze at pc=16 -> HOLD
        step("frz16", 1, 1, 0, 0);
        step("hold1", 0, 1, 0, 0);
        chk("hold.instr", instruction_out, 32'h16 ^ 32'h0 ^ 32'hA5A5_0000 ^ 32'h6);
        step("hold2", 0, 0, 0, 0);
        chk("hold.next", imem_addr, 32'd20);
        step("seq20", 1, 0, 0, 0);
        // Branch while waiting at pc=24 -> DISCARD
        step("br24", 0, 0, 1, 32'h100);
        step("disc1", 0, 0, 0, 0);
        chk("disc.addr", imem_addr, 32'd24);
        step("disc2", 1, 0, 0, 0);
        chk("disc.target", imem_addr, 32'h100);
        // Two redirects during one outstanding request
        step("br100", 0, 0, 1, 32'h100);
        step("disc3", 0, 0, 1, 32'h200);
        step("disc4", 1, 0, 0, 0);
        chk("lastwins", imem_addr, 32'h200);
        // Branch together with freeze in HOLD
        step("frz200", 1, 1, 0, 0);
        step("holdbr", 0, 1, 1, 32'h300);
        chk("holdbr.addr", imem_addr, 32'h300);
        // Reset in the middle of DISCARD
        step("br300", 0, 0, 1, 32'h400);
        #2 rst = 1'b1;
        #1;
        chk("midrst.req",   32'(imem_req),    32'h0);
        chk("midrst.addr",  imem_addr,        32'h0);
        chk("midrst.stall", 32'(fetch_stall), 32'h1);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        step("idle2", 0, 0, 0, 0);
        // PC wrap
        step("brwrap", 1, 0, 1, 32'hFFFF_FFFC);
        chk("wrap.pcout", pc_out, 32'h0);
        step("wrapf", 1, 0, 0, 0);
        chk("wrap.addr", imem_addr, 32'h0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            logic        r, f, b;
            logic [31:0] a;
            r = ($urandom_range(0, 2) != 0);
            f = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            step("rand", r, f, b, a);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
